bhand_src: RTL and testbench



---
 rtl/bhand_src.sv | 125 ++++++++++++
 tb/tb_bhand_src.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bhand_src.sv
// Burst source: emits burst_len incrementing beats on a valid/ready stream, then pulses done.
// Optional inter-beat idle gaps are compiled in with `define BHAND_SRC_GAP_EN.
module bhand_src #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  first_data,
  input  logic [COUNT_WIDTH-1:0] burst_len,
  input  logic [COUNT_WIDTH-1:0] gap_len,
  output logic [DATA_WIDTH-1:0]  odata,
  output logic                   odata_vld,
  input  logic                   odata_rdy,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] sent_cnt
);

`ifdef BHAND_SRC_GAP_EN
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
  logic [COUNT_WIDTH-1:0] gap_q;
  logic [COUNT_WIDTH-1:0] gcnt_q;
`else
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  logic unused_gap;
  assign unused_gap = ^gap_len;
`endif

  state_t                 state_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   vld_q;
  logic                   busy_q;
  logic                   done_q;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic [COUNT_WIDTH-1:0] len_q;
  logic [COUNT_WIDTH-1:0] cnt_d;

  // cnt_q never exceeds len_q, so the increment cannot wrap even at the maximum length.
  assign cnt_d = cnt_q + COUNT_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
`ifdef BHAND_SRC_GAP_EN
      gap_q   <= '0;
      gcnt_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q  <= burst_len;
            cnt_q  <= '0;
            data_q <= first_data;
`ifdef BHAND_SRC_GAP_EN
            gap_q  <= gap_len;
`endif
            if (burst_len != '0) begin
              state_q <= SEND;
              vld_q   <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        SEND: begin
          if (vld_q && odata_rdy) begin
            data_q <= data_q + DATA_WIDTH'(1);
            cnt_q  <= cnt_d;
`ifdef BHAND_SRC_GAP_EN
            if (gap_q != '0) begin
              state_q <= GAP;
              vld_q   <= 1'b0;
              gcnt_q  <= gap_q;
            end else
`endif
            if (cnt_d == len_q) begin
              state_q <= DONE;
              vld_q   <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
`ifdef BHAND_SRC_GAP_EN
        GAP: begin
          // Leave after exactly gap_q idle cycles; cnt_q == len_q marks the final beat.
          if (gcnt_q == COUNT_WIDTH'(1)) begin
            if (cnt_q == len_q) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= SEND;
              vld_q   <= 1'b1;
            end
          end else begin
            gcnt_q <= gcnt_q - COUNT_WIDTH'(1);
          end
        end
`endif
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign odata     = data_q;
  assign odata_vld = vld_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sent_cnt  = cnt_q;

endmodule

// File: tb/tb_bhand_src.sv
// Testbench for bhand_src: vector table of bursts with a beat scoreboard, plus reset and gap sequences.
module tb_bhand_src;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] first_data = '0;
  logic [CW-1:0] burst_len = '0;
  logic [CW-1:0] gap_len = '0;
  logic [DW-1:0] odata;
  logic          odata_vld;
  logic          odata_rdy = 1'b0;
  logic          busy;
  logic          done;
  logic [CW-1:0] sent_cnt;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_beat;
  logic          stall_q = 1'b0;
  logic [DW-1:0] stall_data;

  bhand_src #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .first_data(first_data),
    .burst_len(burst_len), .gap_len(gap_len), .odata(odata),
    .odata_vld(odata_vld), .odata_rdy(odata_rdy), .busy(busy),
    .done(done), .sent_cnt(sent_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Beat scoreboard and hold-while-stalled monitor.
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("vld_hold", {31'd0, odata_vld}, 32'd1);
        check("data_hold", {24'd0, odata}, {24'd0, stall_data});
      end
      if (odata_vld && odata_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {24'd0, odata}, 32'hFFFF_FFFF);
        end else begin
          check("beat", {24'd0, odata}, {24'd0, exp_q.pop_front()});
        end
        last_beat = odata;
      end
      stall_q    = odata_vld && !odata_rdy;
      stall_data = odata;
    end
  end

  typedef struct {
    logic [DW-1:0] first;
    logic [CW-1:0] len;
    logic [7:0]    pat;       // rdy during cycle c after start is pat[(c-1)%8]
    logic          hold;      // keep start asserted for the whole burst
    logic [DW-1:0] exp_last;  // expected final beat value
  } vec_t;

  function automatic logic rdy_at(input logic [7:0] pat, input int c);
    return pat[(c - 1) % 8];
  endfunction

  task automatic run_burst(input vec_t v);
    int exp_done_cyc;
    int acc;
    int done_cyc;
    exp_done_cyc = 1;
    acc = 0;
    while (acc < int'(v.len)) begin
      if (rdy_at(v.pat, exp_done_cyc)) acc++;
      exp_done_cyc++;
    end
    for (int i = 0; i < int'(v.len); i++) exp_q.push_back(v.first + DW'(i));
    first_data = v.first;
    burst_len  = v.len;
    start      = 1'b1;
    @(posedge clk); #1;
    start = v.hold;
    first_data = ~v.first;
    done_cyc = -1;
    for (int c = 1; c <= 80; c++) begin
      odata_rdy = rdy_at(v.pat, c);
      @(negedge clk);
      if (c == 1 && v.len != 0) begin
        check("first_vld", {31'd0, odata_vld}, 32'd1);
        check("first_data", {24'd0, odata}, {24'd0, v.first});
        check("first_busy", {31'd0, busy}, 32'd1);
      end
      if (done) begin
        done_cyc = c;
        check("done_busy", {31'd0, busy}, 32'd0);
        check("done_vld", {31'd0, odata_vld}, 32'd0);
        break;
      end
      @(posedge clk); #1;
    end
    check("done_cycle", done_cyc, exp_done_cyc);
    @(posedge clk); #1;
    start = 1'b0;
    odata_rdy = 1'b0;
    @(negedge clk);
    check("after_done", {31'd0, done}, 32'd0);
    check("after_busy", {31'd0, busy}, 32'd0);
    check("sent_cnt", {28'd0, sent_cnt}, {28'd0, v.len});
    check("queue_empty", exp_q.size(), 0);
    if (v.len != 0) check("last_beat", {24'd0, last_beat}, {24'd0, v.exp_last});
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'h10, 4'd4,  8'hFF, 1'b0, 8'h13};
    vecs[1] = '{8'h00, 4'd3,  8'hF2, 1'b0, 8'h02};
    vecs[2] = '{8'hFE, 4'd3,  8'hFF, 1'b0, 8'h00};
    vecs[3] = '{8'h55, 4'd0,  8'hFF, 1'b0, 8'h00};
    vecs[4] = '{8'h05, 4'd15, 8'hFF, 1'b1, 8'h13};
    vecs[5] = '{8'hA0, 4'd2,  8'hAA, 1'b1, 8'hA1};

    #1;
    check("rst_vld", {31'd0, odata_vld}, 32'd0);
    check("rst_data", {24'd0, odata}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_cnt", {28'd0, sent_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_burst(vecs[i]);

    // Reset after the 2nd of 5 beats: abandon burst, no done, then a normal burst.
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h31);
    first_data = 8'h30;
    burst_len  = 4'd5;
    odata_rdy  = 1'b1;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_vld", {31'd0, odata_vld}, 32'd0);
    check("mid_rst_data", {24'd0, odata}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_cnt", {28'd0, sent_cnt}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_done", {31'd0, done}, 32'd0);
    end
    check("mid_rst_beats", exp_q.size(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    odata_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_rst_done", {31'd0, done}, 32'd0);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
    end
    @(posedge clk); #1;
    run_burst('{8'h40, 4'd2, 8'hFF, 1'b0, 8'h41});

`ifdef BHAND_SRC_GAP_EN
    begin
      logic [8:0] vpat;
      logic [8:0] want;
      want = 9'b001001001;  // bit c-1 = vld in cycle c: 1,0,0,1,0,0,1,0,0
      vpat = '0;
      for (int i = 0; i < 3; i++) exp_q.push_back(8'h20 + DW'(i));
      first_data = 8'h20;
      burst_len  = 4'd3;
      gap_len    = 4'd2;
      odata_rdy  = 1'b1;
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 9; c++) begin
        @(negedge clk);
        vpat[c-1] = odata_vld;
        check("gap_no_done", {31'd0, done}, 32'd0);
      end
      check("gap_vld_pattern", {23'd0, vpat}, {23'd0, want});
      @(negedge clk);
      check("gap_done", {31'd0, done}, 32'd1);
      check("gap_queue", exp_q.size(), 0);
      gap_len = '0;
      odata_rdy = 1'b0;
      @(posedge clk); #1;
      exp_q.delete();
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
